// File: rtl/am_insert_lanes.sv
// Multi-lane 64b/66b alignment-marker inserter with per-lane BIP parity.
// One marker on every lane after each GAP accepted blocks.
module am_insert_lanes #(
    parameter int LANE_N = 4,
    parameter int DATA_W = 64,
    parameter int GAP    = 16383,
    parameter logic [LANE_N*24-1:0] AM_M012 =
        96'h3D79A2_9B65C5_E6C4F0_477690
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid_i,
    input  logic [LANE_N*2-1:0]        head_i,
    input  logic [LANE_N*DATA_W-1:0]   data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [LANE_N*2-1:0]        head_o,
    output logic [LANE_N*DATA_W-1:0]   data_o
);

    localparam int CW = $clog2(GAP + 1);
    localparam logic [CW-1:0] GAP_C = CW'(GAP);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [LANE_N*8-1:0]        bip_q, bip_d;
    logic                       valid_q, valid_d;
    logic [LANE_N*2-1:0]        head_q, head_d;
    logic [LANE_N*DATA_W-1:0]   data_q, data_d;

    logic am_slot;
    logic accept;

    // Payload bit j lands in BIP bit j mod 8; header bits feed BIP bits 3 and 4.
    function automatic logic [7:0] block_bip(
        input logic [1:0]        h,
        input logic [DATA_W-1:0] d
    );
        logic [7:0] p;
        p = '0;
        for (int j = 0; j < DATA_W; j++) begin
            p[3'(j)] = p[3'(j)] ^ d[j];
        end
        p[3] = p[3] ^ h[0];
        p[4] = p[4] ^ h[1];
        return p;
    endfunction

    // Bytes 0..7: M0,M1,M2,BIP3,~M0,~M1,~M2,~BIP3 (m = {M2,M1,M0}).
    function automatic logic [DATA_W-1:0] am_block(
        input logic [23:0] m,
        input logic [7:0]  bip
    );
        logic [DATA_W-1:0] b;
        b = '0;
        b[63:0] = {~bip, ~m, bip, m};
        return b;
    endfunction

    assign am_slot = (cnt_q == GAP_C);
    assign ready_o = ~reset & ~am_slot;
    assign accept  = valid_i & ready_o;

    always_comb begin
        logic [DATA_W-1:0] mk;
        logic [DATA_W-1:0] din;
        logic [1:0]        hin;
        cnt_d   = cnt_q;
        bip_d   = bip_q;
        valid_d = 1'b0;
        head_d  = head_q;
        data_d  = data_q;
        mk      = '0;
        din     = '0;
        hin     = '0;
        if (am_slot) begin
            cnt_d   = '0;
            valid_d = 1'b1;
            for (int l = 0; l < LANE_N; l++) begin
                mk = am_block(AM_M012[l*24 +: 24], bip_q[l*8 +: 8]);
                head_d[l*2 +: 2]        = 2'b01;
                data_d[l*DATA_W +: DATA_W] = mk;
                // Next interval's parity starts with its leading marker.
                bip_d[l*8 +: 8]         = block_bip(2'b01, mk);
            end
        end else if (accept) begin
            cnt_d   = cnt_q + 1'b1;
            valid_d = 1'b1;
            head_d  = head_i;
            data_d  = data_i;
            for (int l = 0; l < LANE_N; l++) begin
                hin = head_i[l*2 +: 2];
                din = data_i[l*DATA_W +: DATA_W];
                bip_d[l*8 +: 8] = bip_q[l*8 +: 8] ^ block_bip(hin, din);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= GAP_C;
            bip_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            data_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            bip_q   <= bip_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = head_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_am_insert_lanes.sv
// Bench for am_insert_lanes: 4-lane GAP=4 and 20-lane GAP=2 instances
// checked every cycle against a block-level marker/parity model.
module tb_am_insert_lanes;

    function automatic logic [479:0] mk_am();
        logic [479:0] r;
        r = '0;
        for (int l = 0; l < 20; l++) begin
            r[l*24 +: 24] = {8'(8'h30 + l), 8'(8'h60 + 2*l), 8'(8'hA0 + l)};
        end
        return r;
    endfunction

    localparam logic [479:0] AM_B = mk_am();

    logic         clk = 1'b0;
    logic         reset;
    logic         valid;
    logic [7:0]   headA_i;
    logic [255:0] dataA_i;
    logic [39:0]  headB_i;
    logic [1279:0] dataB_i;
    logic         readyA, readyB, validA, validB;
    logic [7:0]   headA_o;
    logic [255:0] dataA_o;
    logic [39:0]  headB_o;
    logic [1279:0] dataB_o;

    always #5 clk = ~clk;

    am_insert_lanes #(.LANE_N(4), .DATA_W(64), .GAP(4)) uA (
        .clk(clk), .reset(reset), .valid_i(valid),
        .head_i(headA_i), .data_i(dataA_i), .ready_o(readyA),
        .valid_o(validA), .head_o(headA_o), .data_o(dataA_o)
    );

    am_insert_lanes #(.LANE_N(20), .DATA_W(64), .GAP(2), .AM_M012(AM_B)) uB (
        .clk(clk), .reset(reset), .valid_i(valid),
        .head_i(headB_i), .data_i(dataB_i), .ready_o(readyB),
        .valid_o(validB), .head_o(headB_o), .data_o(dataB_o)
    );

    int ncmp = 0;
    int nfail = 0;

    logic [1:0]  hin [20];
    logic [63:0] din [20];

    // Model state: index 0 = 4-lane instance, 1 = 20-lane instance.
    int          LN [2] = '{4, 20};
    int          GP [2] = '{4, 2};
    logic [23:0] amt [2][20];
    logic [7:0]  mb  [2][20];
    logic [1:0]  mh  [2][20];
    logic [63:0] md  [2][20];
    bit          mv  [2];
    bit          mp  [2];
    int          mc  [2];
    bit          expRA;

    int          seq;
    int          tickno;
    int          mk_pos [$];
    logic [31:0] got_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_par(input logic [1:0] h,
                                         input logic [63:0] d);
        logic [65:0] blk;
        logic [7:0]  p;
        blk = {d, h};
        p = '0;
        for (int k = 0; k < 66; k++) begin
            if (k == 0)      p[3] = p[3] ^ blk[k];
            else if (k == 1) p[4] = p[4] ^ blk[k];
            else             p[3'(k-2)] = p[3'(k-2)] ^ blk[k];
        end
        return p;
    endfunction

    function automatic logic [63:0] m_am(input logic [23:0] am,
                                         input logic [7:0] b);
        logic [7:0]  by [8];
        logic [63:0] r;
        by[0] = am[7:0];
        by[1] = am[15:8];
        by[2] = am[23:16];
        by[3] = b;
        for (int j = 0; j < 4; j++) by[4+j] = ~by[j];
        for (int j = 0; j < 8; j++) r[8*j +: 8] = by[j];
        return r;
    endfunction

    task automatic model_step(input int i, input bit rst, input bit v);
        if (rst) begin
            mp[i] = 1; mc[i] = 0; mv[i] = 0;
            for (int l = 0; l < 20; l++) begin
                mb[i][l] = '0; mh[i][l] = '0; md[i][l] = '0;
            end
        end else if (mp[i]) begin
            mp[i] = 0; mc[i] = 0; mv[i] = 1;
            for (int l = 0; l < LN[i]; l++) begin
                mh[i][l] = 2'b01;
                md[i][l] = m_am(amt[i][l], mb[i][l]);
                mb[i][l] = m_par(2'b01, md[i][l]);
            end
        end else if (v) begin
            mv[i] = 1;
            mc[i]++;
            if (mc[i] == GP[i]) mp[i] = 1;
            for (int l = 0; l < LN[i]; l++) begin
                mh[i][l] = hin[l];
                md[i][l] = din[l];
                mb[i][l] = mb[i][l] ^ m_par(hin[l], din[l]);
            end
        end else begin
            mv[i] = 0;
        end
    endtask

    task automatic set_lanes(input logic [1:0] h, input logic [31:0] s);
        for (int l = 0; l < 20; l++) begin
            hin[l] = h;
            din[l] = {s, 32'(l)};
        end
    endtask

    task automatic tick(input bit rst, input bit v);
        bit erb;
        reset = rst;
        valid = v;
        for (int l = 0; l < 4; l++) begin
            headA_i[l*2 +: 2] = hin[l];
            dataA_i[l*64 +: 64] = din[l];
        end
        for (int l = 0; l < 20; l++) begin
            headB_i[l*2 +: 2] = hin[l];
            dataB_i[l*64 +: 64] = din[l];
        end
        #1;
        expRA = !rst && !mp[0];
        erb   = !rst && !mp[1];
        chk("readyA", 64'(readyA), 64'(expRA));
        chk("readyB", 64'(readyB), 64'(erb));
        model_step(0, rst, v);
        model_step(1, rst, v);
        @(posedge clk);
        #1;
        chk("validA", 64'(validA), 64'(mv[0]));
        chk("validB", 64'(validB), 64'(mv[1]));
        for (int l = 0; l < 4; l++) begin
            chk($sformatf("A.head[%0d]", l), 64'(headA_o[l*2 +: 2]), 64'(mh[0][l]));
            chk($sformatf("A.data[%0d]", l), dataA_o[l*64 +: 64], md[0][l]);
        end
        for (int l = 0; l < 20; l++) begin
            chk($sformatf("B.head[%0d]", l), 64'(headB_o[l*2 +: 2]), 64'(mh[1][l]));
            chk($sformatf("B.data[%0d]", l), dataB_o[l*64 +: 64], md[1][l]);
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        amt[0][0] = 24'h477690; amt[0][1] = 24'hE6C4F0;
        amt[0][2] = 24'h9B65C5; amt[0][3] = 24'h3D79A2;
        for (int l = 4; l < 20; l++) amt[0][l] = '0;
        for (int l = 0; l < 20; l++) amt[1][l] = AM_B[l*24 +: 24];
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; mp[i] = 1; mc[i] = 0;
            for (int l = 0; l < 20; l++) begin
                mb[i][l] = '0; mh[i][l] = '0; md[i][l] = '0;
            end
        end
        reset = 1'b1;
        valid = 1'b0;
        set_lanes(2'b10, 32'd0);
        headA_i = '0; dataA_i = '0; headB_i = '0; dataB_i = '0;
        @(negedge clk);

        // Reset held 3 cycles, then the first marker slot.
        repeat (3) tick(1, 0);
        chk("rst.validA", 64'(validA), 64'd0);
        chk("rst.dataA0", dataA_o[63:0], 64'd0);
        tick(0, 0);
        chk("am1.headA0", 64'(headA_o[1:0]), 64'h1);
        chk("am1.dataA0", dataA_o[63:0], 64'hFFB8896F00477690);
        chk("am1.dataB19", dataB_o[19*64 +: 64], 64'hFFBC794C004386B3);
        for (int l = 0; l < 20; l++)
            chk($sformatf("am1.headB[%0d]", l), 64'(headB_o[l*2 +: 2]), 64'h1);

        // BIP: four head=10 zero blocks, then marker (valid held high).
        for (int l = 0; l < 20; l++) begin hin[l] = 2'b10; din[l] = '0; end
        repeat (4) tick(0, 1);
        tick(0, 1);
        chk("bip.headA0", 64'(headA_o[1:0]), 64'h1);
        chk("bip.bip3A0", 64'(dataA_o[31:24]), 64'h08);
        chk("bip.bip7A0", 64'(dataA_o[63:56]), 64'hF7);

        // Steady stream: 20 cycles, payload advances only when accepted.
        seq = 0;
        for (int t = 0; t < 20; t++) begin
            set_lanes(2'b10, 32'(seq));
            tick(0, 1);
            if (expRA) seq++;
            if (validA && headA_o[1:0] == 2'b10) got_q.push_back(dataA_o[63:32]);
            else if (validA && headA_o[1:0] == 2'b01) mk_pos.push_back(t);
        end
        chk("steady.ndata", 64'(got_q.size()), 64'd16);
        chk("steady.nmark", 64'(mk_pos.size()), 64'd4);
        foreach (got_q[k]) chk($sformatf("steady.order[%0d]", k), 64'(got_q[k]), 64'(k));
        foreach (mk_pos[k]) chk($sformatf("steady.mpos[%0d]", k), 64'(mk_pos[k]), 64'(5*k + 4));

        // Bubbles: valid 1,0,0,1,1,0,1 then the marker slot.
        set_lanes(2'b10, 32'd16); tick(0, 1);
        tick(0, 0);
        chk("bub.validA", 64'(validA), 64'd0);
        chk("bub.holdA0", 64'(dataA_o[63:32]), 64'd16);
        tick(0, 0);
        chk("bub.hold2A0", 64'(dataA_o[63:32]), 64'd16);
        set_lanes(2'b10, 32'd17); tick(0, 1);
        set_lanes(2'b10, 32'd18); tick(0, 1);
        tick(0, 0);
        set_lanes(2'b10, 32'd19); tick(0, 1);
        chk("bub.last", 64'(dataA_o[63:32]), 64'd19);
        tick(0, 0);
        chk("bub.mkvalid", 64'(validA), 64'd1);
        chk("bub.mkhead", 64'(headA_o[1:0]), 64'h1);
        chk("bub.mkm0", 64'(dataA_o[7:0]), 64'h90);

        // Reset mid-interval after two data blocks.
        set_lanes(2'b10, 32'd20); tick(0, 1);
        set_lanes(2'b10, 32'd21); tick(0, 1);
        tick(1, 1);
        tick(1, 1);
        tick(0, 1);
        chk("mid.dataA0", dataA_o[63:0], 64'hFFB8896F00477690);
        for (int t = 0; t < 4; t++) begin
            set_lanes(2'b10, 32'(30 + t));
            tick(0, 1);
        end
        chk("mid.lastdata", 64'(dataA_o[63:32]), 64'd33);
        tick(0, 1);
        chk("mid.remark", 64'(headA_o[1:0]), 64'h1);

        // Random traffic with arbitrary headers and occasional reset.
        for (int t = 0; t < 60; t++) begin
            for (int l = 0; l < 20; l++) begin
                hin[l] = 2'($urandom);
                din[l] = {$urandom, $urandom};
            end
            tick($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
